oscill_nios_led_seq: RTL

OSCILL_NIOS_LED_SEQ -- requirements
Module: oscill_nios_led_seq

---
 rtl/oscill_nios_led_seq.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/oscill_nios_led_seq.sv
// Avalon-MM LED sequencer: static, blink, rotate and bounce patterns advanced by a prescaler tick.
// Optional brightness PWM is built in when OSCILL_LED_SEQ_PWM_EN is defined.
module oscill_nios_led_seq #(
    parameter int LED_WIDTH   = 10,
    parameter int PRESC_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic [LED_WIDTH-1:0] out_port
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_ROTATE = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PATTERN = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    state_t                 state_q, state_d;
    logic                   en_q, en_d;
    logic [1:0]             mode_q, mode_d;
    logic [LED_WIDTH-1:0]   pattern_q, pattern_d;
    logic [PRESC_WIDTH-1:0] period_q, period_d;
    logic [7:0]             step_cnt_q, step_cnt_d;
    logic [LED_WIDTH-1:0]   shreg_q, shreg_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic                   phase_q, phase_d;
    logic [LED_WIDTH-1:0]   out_q, out_d;

`ifdef OSCILL_LED_SEQ_PWM_EN
    logic [7:0]             duty_q, duty_d;
    logic [7:0]             pwm_cnt_q, pwm_cnt_d;
`endif

    logic                   wr;
    logic                   wr_ctrl;
    logic                   wr_pattern;
    logic                   wr_period;
    logic                   wr_status;
    logic                   running;
    logic                   tick;
    logic                   enter;
    logic                   load;
    logic                   step;
    logic                   msb;
    logic                   lsb;
    logic [LED_WIDTH-1:0]   seq_out;
    logic                   unused_wdata;

    assign wr         = chipselect & ~write_n;
    assign wr_ctrl    = wr && (address == ADDR_CTRL);
    assign wr_pattern = wr && (address == ADDR_PATTERN);
    assign wr_period  = wr && (address == ADDR_PERIOD);
    assign wr_status  = wr && (address == ADDR_STATUS);

    assign running = (state_q != IDLE);
    assign tick    = running && (presc_q == period_q);
    assign enter   = wr_ctrl && writedata[0] && (state_q == IDLE);
    // A reload or period change restarts the interval, so a tick on that cycle is dropped.
    assign load    = (wr_pattern && running) || wr_period;
    assign step    = tick && !load;

    assign msb = shreg_q[LED_WIDTH-1];
    assign lsb = shreg_q[0];

    assign unused_wdata = ^writedata;

    // Register file and sequencer next-state.
    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        mode_d     = mode_q;
        pattern_d  = pattern_q;
        period_d   = period_q;
        step_cnt_d = step_cnt_q;
        shreg_d    = shreg_q;
        presc_d    = presc_q;
        phase_d    = phase_q;
`ifdef OSCILL_LED_SEQ_PWM_EN
        duty_d     = duty_q;
`endif

        if (wr_ctrl) begin
            en_d   = writedata[0];
            mode_d = writedata[2:1];
`ifdef OSCILL_LED_SEQ_PWM_EN
            duty_d = writedata[15:8];
`endif
        end
        if (wr_pattern) begin
            pattern_d = writedata[LED_WIDTH-1:0];
        end
        if (wr_period) begin
            period_d = writedata[PRESC_WIDTH-1:0];
        end

        if (!running || load || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        if (step) begin
            step_cnt_d = step_cnt_q + 8'd1;
            case (mode_q)
                MODE_BLINK: begin
                    phase_d = ~phase_q;
                end
                MODE_ROTATE: begin
                    shreg_d = {shreg_q[LED_WIDTH-2:0], msb};
                end
                MODE_BOUNCE: begin
                    // An empty register or one lit at both ends has nowhere to go.
                    if ((shreg_q != '0) && !(msb && lsb)) begin
                        if (state_q == FWD) begin
                            if (msb) begin
                                state_d = REV;
                                shreg_d = {1'b0, shreg_q[LED_WIDTH-1:1]};
                            end else begin
                                shreg_d = {shreg_q[LED_WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            if (lsb) begin
                                state_d = FWD;
                                shreg_d = {shreg_q[LED_WIDTH-2:0], 1'b0};
                            end else begin
                                shreg_d = {1'b0, shreg_q[LED_WIDTH-1:1]};
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        if (wr_pattern && running) begin
            shreg_d = writedata[LED_WIDTH-1:0];
        end

        if (enter) begin
            state_d = FWD;
            shreg_d = pattern_q;
            phase_d = 1'b1;
        end

        if (wr_ctrl && !writedata[0]) begin
            state_d = IDLE;
        end

        if (wr_status) begin
            step_cnt_d = '0;
        end
    end

    // LED value before any brightness gating; registered into out_q.
    always_comb begin
        seq_out = pattern_q;
        if (running) begin
            case (mode_q)
                MODE_STATIC: seq_out = pattern_q;
                MODE_BLINK:  seq_out = phase_q ? pattern_q : '0;
                default:     seq_out = shreg_q;
            endcase
        end
    end

`ifdef OSCILL_LED_SEQ_PWM_EN
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        out_d     = seq_out & {LED_WIDTH{pwm_cnt_q < duty_q}};
    end
`else
    always_comb begin
        out_d = seq_out;
    end
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[0]   = en_q;
                readdata[2:1] = mode_q;
`ifdef OSCILL_LED_SEQ_PWM_EN
                readdata[15:8] = duty_q;
`endif
            end
            ADDR_PATTERN: readdata[LED_WIDTH-1:0]   = pattern_q;
            ADDR_PERIOD:  readdata[PRESC_WIDTH-1:0] = period_q;
            default: begin
                readdata[0]    = running;
                readdata[1]    = (state_q == REV);
                readdata[15:8] = step_cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            mode_q     <= MODE_STATIC;
            pattern_q  <= '0;
            period_q   <= '0;
            step_cnt_q <= '0;
            shreg_q    <= '0;
            presc_q    <= '0;
            phase_q    <= 1'b1;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            pattern_q  <= pattern_d;
            period_q   <= period_d;
            step_cnt_q <= step_cnt_d;
            shreg_q    <= shreg_d;
            presc_q    <= presc_d;
            phase_q    <= phase_d;
            out_q      <= out_d;
        end
    end

`ifdef OSCILL_LED_SEQ_PWM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_q    <= 8'hFF;
            pwm_cnt_q <= '0;
        end else begin
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end
`endif

    assign out_port = out_q;

endmodule
